// File: rtl/router_pkg.sv
// Shared types and header layout constants for the router egress read path.
package router_pkg;

  typedef enum logic [1:0] {HDR, PAY, PAR} state_t;

  localparam int ADDR_W          = 2;
  localparam int HDR_LEN_MSB     = 7;
  // Header byte is {len, addr}; the length field sits directly above the address.
  localparam int HDR_LEN_LSB     = ADDR_W;
  localparam int LEN_W           = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int DEFAULT_TIMEOUT = 30;

endpackage

// File: rtl/router_stall_timer.sv
// Counts consecutive consumer-stall cycles; expire is combinational on the last stalled cycle,
// pulse is its registered one-cycle copy used to flush the FIFO and flag the drop.
module router_stall_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMO_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic stall,
  output logic expire,
  output logic pulse
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  // A handshake removes the stall, so a simultaneous ready never expires.
  assign expire = stall & (cnt == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= expire;
      if (stall && !expire) begin
        cnt <= cnt + TMO_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/router_egress_reader.sv
// Drains header, payload and parity bytes from the router FIFO into a valid/ready stage (read-to-valid 2 cycles);
// a TIMEOUT-cycle consumer stall flushes the FIFO and drops the packet. Parity check built with ROUTER_PARITY_CHECK_EN.
module router_egress_reader
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMO_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_enb,
  output logic              fifo_soft_reset,
  output logic [DATA_W-1:0] dout,
  output logic              vld_out,
  input  logic              ready,
  output logic              sop,
  output logic              eop,
  output logic              parity_err,
  output logic              pkt_drop,
  output logic              busy
);

  state_t           state;
  logic             pend;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] hdr_len;
  logic             hs;
  logic             stall;
  logic             expire;
  logic             drop_pulse;

  assign hs      = vld_out & ready;
  assign stall   = vld_out & ~ready;
  assign hdr_len = fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];

  // Gated by resetn so the strobe is low for the whole time the block is held in reset.
  assign fifo_read_enb = resetn & ~fifo_empty & ~pend & (~vld_out | ready) & ~fifo_soft_reset;

  router_stall_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_stall_timer (
    .clock  (clock),
    .resetn (resetn),
    .stall  (stall),
    .expire (expire),
    .pulse  (drop_pulse)
  );

  assign fifo_soft_reset = drop_pulse;
  assign pkt_drop        = drop_pulse;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= HDR;
      pend    <= 1'b0;
      len     <= '0;
      cnt     <= '0;
      dout    <= '0;
      vld_out <= 1'b0;
      sop     <= 1'b0;
      eop     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pend <= fifo_read_enb;
      if (expire) begin
        // Abandon the packet; the FIFO flush happens on the following cycle.
        vld_out <= 1'b0;
        sop     <= 1'b0;
        eop     <= 1'b0;
        busy    <= 1'b0;
        pend    <= 1'b0;
        cnt     <= '0;
        state   <= HDR;
      end else if (pend) begin
        dout    <= fifo_data;
        vld_out <= 1'b1;
        sop     <= (state == HDR);
        eop     <= (state == PAR);
        case (state)
          HDR: begin
            len   <= hdr_len;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (hdr_len != '0) ? PAY : PAR;
          end
          PAY: begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len - LEN_W'(1)) begin
              state <= PAR;
            end
          end
          PAR:     state <= HDR;
          default: state <= HDR;
        endcase
      end else if (hs) begin
        vld_out <= 1'b0;
        sop     <= 1'b0;
        eop     <= 1'b0;
        if (eop) begin
          busy <= 1'b0;
        end
      end
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] par;
  logic              par_bad;

  // The mismatch is resolved at load time but only reported when the parity byte is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par        <= '0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= hs & eop & par_bad;
      if (pend && !expire) begin
        case (state)
          HDR: begin
            par     <= fifo_data;
            par_bad <= 1'b0;
          end
          PAY:     par <= par ^ fifo_data;
          PAR:     par_bad <= (fifo_data != par);
          default: par <= par;
        endcase
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_egress_reader.sv
// Scoreboard bench for router_egress_reader with a behavioural FIFO model driving the read side.
module tb_router_egress_reader;

`ifdef ROUTER_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock      = 1'b0;
  logic       resetn     = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;
  logic       ready      = 1'b0;
  logic       fifo_read_enb;
  logic       fifo_soft_reset;
  logic [7:0] dout;
  logic       vld_out;
  logic       sop;
  logic       eop;
  logic       parity_err;
  logic       pkt_drop;
  logic       busy;

  typedef struct packed {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
    logic       bad;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo_q[$];
  int         rd_log[$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         cyc       = 0;
  int         n_perr    = 0;
  int         n_drop    = 0;
  int         first_vld = -1;
  bit         perr_pend = 1'b0;
  bit         rd_s      = 1'b0;
  bit         flush_s   = 1'b0;

  router_egress_reader #(
    .DATA_W  (8),
    .TIMEOUT (30),
    .TMO_W   (5)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .fifo_read_enb   (fifo_read_enb),
    .fifo_soft_reset (fifo_soft_reset),
    .dout            (dout),
    .vld_out         (vld_out),
    .ready           (ready),
    .sop             (sop),
    .eop             (eop),
    .parity_err      (parity_err),
    .pkt_drop        (pkt_drop),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input bit corrupt, input bit track);
    logic [7:0] par;
    logic [7:0] b;
    int         len;
    len = int'(hdr[7:2]);
    par = hdr;
    fifo_q.push_back(hdr);
    if (track) sb.push_back(exp_t'{hdr, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      par ^= b;
      fifo_q.push_back(b);
      if (track) sb.push_back(exp_t'{b, 1'b0, 1'b0, 1'b0});
    end
    b = corrupt ? (par ^ 8'h01) : par;
    fifo_q.push_back(b);
    if (track) sb.push_back(exp_t'{b, 1'b0, 1'b1, corrupt & PAR_EN});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, sb.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  // FIFO model: read data appears the cycle after the strobe is sampled.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (flush_s) fifo_q.delete();
    else if (rd_s && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  end

  always @(negedge clock) begin
    exp_t e;
    rd_s    = fifo_read_enb && resetn;
    flush_s = fifo_soft_reset && resetn;
    if (!resetn) begin
      perr_pend = 1'b0;
    end else begin
      if (perr_pend) check_eq("perr_pulse", parity_err, 1);
      else if (parity_err) check_eq("perr_spurious", parity_err, 0);
      if (parity_err) n_perr++;
      perr_pend = 1'b0;
      if (pkt_drop) begin
        n_drop++;
        check_eq("sreset_with_drop", fifo_soft_reset, 1);
      end
      if (fifo_read_enb) rd_log.push_back(cyc);
      if (vld_out && first_vld < 0) first_vld = cyc;
      if (vld_out && ready) begin
        check_eq("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("dout", dout, e.dat);
          check_eq("sop", sop, e.sop);
          check_eq("eop", eop, e.eop);
          perr_pend = e.eop && e.bad;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n, v, d0, n0, nv, nd, nr, bad;
    logic [7:0] held;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_vld", vld_out, 0);
    check_eq("rst_sop_eop", {sop, eop}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {parity_err, pkt_drop, fifo_soft_reset, fifo_read_enb}, 0);
    resetn = 1'b1;
    ready  = 1'b1;

    // Full-length packet, clean parity, consumer always ready.
    @(negedge clock);
    rd_log.delete();
    first_vld = -1;
    push_pkt(8'h39, 1'b0, 1'b1);
    wait_drain("t1_drain", 200);
    check_eq("t1_reads", rd_log.size(), 16);
    bad = 0;
    for (int i = 1; i < rd_log.size(); i++) if (rd_log[i] - rd_log[i-1] != 2) bad++;
    check_eq("t1_read_spacing", bad, 0);
    check_eq("t1_latency", (rd_log.size() > 0) ? first_vld - rd_log[0] : -1, 2);
    check_eq("t1_busy_idle", busy, 0);
    check_eq("t1_no_perr", n_perr, 0);

    // Corrupted parity byte.
    n0 = n_perr;
    push_pkt(8'h39, 1'b1, 1'b1);
    wait_drain("t2_drain", 200);
    check_eq("t2_perr_count", n_perr - n0, PAR_EN ? 1 : 0);

    // Zero-length payload.
    rd_log.delete();
    push_pkt(8'h02, 1'b0, 1'b1);
    wait_drain("t3_drain", 50);
    check_eq("t3_reads", rd_log.size(), 2);
    check_eq("t3_busy_idle", busy, 0);

    // Short mid-payload stall: held output, no reads, no drop.
    push_pkt(8'h15, 1'b0, 1'b1);
    n = 0;
    while (sb.size() > 4 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1 ready = 1'b0;
    nv = 0; nd = 0; nr = 0; d0 = n_drop; held = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (fifo_read_enb) nr++;
      if (i == 1) held = dout;
      if (i >= 1) begin
        if (!vld_out) nv++;
        if (dout !== held) nd++;
      end
    end
    check_eq("t4_busy", busy, 1);
    check_eq("t4_vld_held", nv, 0);
    check_eq("t4_dout_held", nd, 0);
    check_eq("t4_no_read", nr, 0);
    check_eq("t4_no_drop", n_drop - d0, 0);
    @(posedge clock);
    #1 ready = 1'b1;
    wait_drain("t4_drain", 200);

    // Header held past the timeout: flush and drop.
    @(posedge clock);
    #1 ready = 1'b0;
    @(negedge clock);
    push_pkt(8'h21, 1'b0, 1'b0);
    d0 = n_drop;
    n = 0;
    while (!vld_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    v = cyc;
    check_eq("t5_hdr_held", {vld_out, sop}, 2'b11);
    n = 0;
    while (!pkt_drop && n < 60) begin
      @(negedge clock);
      n++;
    end
    check_eq("t5_tmo_cycles", cyc - v, 30);
    check_eq("t5_sreset", fifo_soft_reset, 1);
    check_eq("t5_vld_cleared", vld_out, 0);
    check_eq("t5_busy_cleared", busy, 0);
    check_eq("t5_no_read", fifo_read_enb, 0);
    @(negedge clock);
    check_eq("t5_pulse_width", {pkt_drop, fifo_soft_reset}, 0);
    check_eq("t5_drop_count", n_drop - d0, 1);
    @(posedge clock);
    #1 ready = 1'b1;
    @(negedge clock);
    push_pkt(8'h0D, 1'b0, 1'b1);
    wait_drain("t5_next_pkt", 100);

    // Asynchronous reset mid-payload.
    push_pkt(8'h29, 1'b0, 1'b1);
    n = 0;
    while (sb.size() > 8 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    check_eq("t6_reset_outs", {dout, vld_out, sop, eop, busy, fifo_read_enb, fifo_soft_reset, pkt_drop, parity_err}, 0);
    fifo_q.delete();
    sb.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    push_pkt(8'h0D, 1'b0, 1'b1);
    wait_drain("t6_next_pkt", 100);

    check_eq("total_drops", n_drop, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
